// File: rtl/contrast_inverse.sv
// contrast_inverse
//   Streaming inverse of the fixed contrast stretch:
//     outv = min(255, floor((inv + N) * FRAC_DEN / FRAC_NUM))
//   A 17-step restoring divider produces one quotient bit per cycle, MSB first.
//   Valid/ready on both sides; the result is held in DONE until consumed.
//
//   clock   in   sole clock, rising edge
//   reset   in   synchronous, active-high
//   ivalid  in   inv valid this cycle
//   iready  out  block accepts inv this cycle (combinational from oready in DONE)
//   inv     in   8-bit stretched pixel
//   ovalid  out  outv valid and stable (registered)
//   oready  in   downstream accepts outv
//   outv    out  8-bit recovered pixel (registered)
//
//   state | meaning
//   IDLE  | waiting for a pixel, iready = 1
//   DIV   | 17 division iterations, counter 0..16
//   DONE  | result held on outv until oready; may accept the next pixel on the same edge
module contrast_inverse #(
    parameter int FRAC_NUM = 3,
    parameter int FRAC_DEN = 2,
    parameter int N        = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ivalid,
    output logic       iready,
    input  logic [7:0] inv,
    output logic       ovalid,
    input  logic       oready,
    output logic [7:0] outv
);

    if (FRAC_NUM < 1 || FRAC_NUM > 255) begin : g_bad_num
        $error("contrast_inverse: FRAC_NUM must be 1..255");
    end
    if (FRAC_DEN < 1 || FRAC_DEN > 255) begin : g_bad_den
        $error("contrast_inverse: FRAC_DEN must be 1..255");
    end
    if (N < 0 || N > 255) begin : g_bad_n
        $error("contrast_inverse: N must be 0..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [8:0]  DIVISOR = 9'(FRAC_NUM);
    localparam logic [16:0] OFFSET  = 17'(N);
    localparam logic [16:0] SCALE   = 17'(FRAC_DEN);

    state_t      state, state_nxt;
    logic [16:0] dividend;
    logic [16:0] quot;
    logic [8:0]  rem;
    logic [4:0]  cnt;

    logic        accept;
    logic        last;
    logic [16:0] prod;
    logic [8:0]  rem_shift;
    logic [8:0]  rem_sub;
    logic        rem_ge;
    logic [16:0] quot_nxt;

    // Product fits in 17 bits: 510 * 255 = 130050 < 2^17.
    assign prod = (17'(inv) + OFFSET) * SCALE;

    // The remainder is always below the divisor, so rem[8] stays 0; it is
    // folded into the compare so that a set bit still means "subtract".
    assign rem_shift = {rem[7:0], dividend[16]};
    assign rem_ge    = rem[8] || (rem_shift >= DIVISOR);
    assign rem_sub   = rem_shift - DIVISOR;
    assign quot_nxt  = {quot[15:0], rem_ge};
    assign last      = (cnt == 5'd16);
    assign accept    = ivalid && iready;

    always_comb begin
        state_nxt = state;
        iready    = 1'b0;
        case (state)
            IDLE: begin
                iready = 1'b1;
                if (ivalid) state_nxt = DIV;
            end
            DIV: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (oready) begin
                    iready    = 1'b1;
                    state_nxt = ivalid ? DIV : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            dividend <= '0;
            quot     <= '0;
            rem      <= '0;
            cnt      <= '0;
            outv     <= '0;
            ovalid   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                dividend <= prod;
                quot     <= '0;
                rem      <= '0;
                cnt      <= '0;
            end else if (state == DIV) begin
                dividend <= {dividend[15:0], 1'b0};
                rem      <= rem_ge ? rem_sub : rem_shift;
                quot     <= quot_nxt;
                cnt      <= cnt + 5'd1;
                if (last) begin
                    outv   <= (|quot_nxt[16:8]) ? 8'hFF : quot_nxt[7:0];
                    ovalid <= 1'b1;
                end
            end
            if (state == DONE && oready) ovalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_contrast_inverse.sv
module tb_contrast_inverse;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ivalid = 1'b0;
    logic [7:0] inv = 8'd0;
    logic       oready = 1'b0;
    logic       iready, ovalid;
    logic [7:0] outv;
    logic       iready_s, ovalid_s;
    logic [7:0] outv_s;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    contrast_inverse dut (
        .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready), .inv(inv),
        .ovalid(ovalid), .oready(oready), .outv(outv)
    );

    contrast_inverse #(.FRAC_NUM(1), .FRAC_DEN(2), .N(64)) dut_s (
        .clock(clock), .reset(reset), .ivalid(ivalid), .iready(iready_s), .inv(inv),
        .ovalid(ovalid_s), .oready(oready), .outv(outv_s)
    );

    function automatic int ref_out(input int v, input int num, input int den, input int n);
        int r;
        r = ((v + n) * den) / num;
        return (r > 255) ? 255 : r;
    endfunction

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Waits for ovalid after an accept edge; returns cycles from accept.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!ovalid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic do_pixel(input int v, input int exp_d);
        int lat;
        @(negedge clock);
        inv = 8'(v); ivalid = 1'b1; oready = 1'b0;
        #1 chk_eq("iready_idle", int'(iready), 1);
        @(negedge clock);
        ivalid = 1'b0;
        wait_out(lat);
        chk_eq("latency", lat, 18);
        chk_eq("outv", int'(outv), exp_d);
        chk_eq("ovalid_s", int'(ovalid_s), 1);
        chk_eq("outv_s", int'(outv_s), ref_out(v, 1, 2, 64));
        oready = 1'b1;
        @(negedge clock);
        oready = 1'b0;
        chk_eq("ovalid_clr", int'(ovalid), 0);
    endtask

    initial begin
        int lat, sent, recvd, cyc;
        logic acc_prev;
        int q_d[$];
        int q_s[$];

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk_eq("rst_iready", int'(iready), 1);
        chk_eq("rst_ovalid", int'(ovalid), 0);
        chk_eq("rst_outv", int'(outv), 0);

        do_pixel(128, 128);
        do_pixel(0, 42);
        do_pixel(255, 212);
        do_pixel(200, ref_out(200, 3, 2, 64));
        do_pixel(63, ref_out(63, 3, 2, 64));
        chk_eq("sat_model_200", ref_out(200, 1, 2, 64), 255);

        // back-pressure, then same-edge consume + accept
        @(negedge clock);
        inv = 8'd77; ivalid = 1'b1; oready = 1'b0;
        @(negedge clock);
        ivalid = 1'b0;
        wait_out(lat);
        chk_eq("bp_latency", lat, 18);
        for (int i = 0; i < 10; i++) begin
            ivalid = 1'b1; inv = 8'd30;
            #1;
            chk_eq("bp_outv", int'(outv), 94);
            chk_eq("bp_ovalid", int'(ovalid), 1);
            chk_eq("bp_iready", int'(iready), 0);
            @(negedge clock);
        end
        oready = 1'b1;
        #1 chk_eq("bp_iready_pass", int'(iready), 1);
        @(negedge clock);
        ivalid = 1'b0; oready = 1'b0;
        #1 chk_eq("bp_ovalid_gap", int'(ovalid), 0);
        wait_out(lat);
        chk_eq("bp2_latency", lat, 18);
        chk_eq("bp2_outv", int'(outv), 62);
        chk_eq("bp2_outv_s", int'(outv_s), ref_out(30, 1, 2, 64));
        oready = 1'b1;
        @(negedge clock);
        oready = 1'b0;

        // reset during DIV iteration 8
        @(negedge clock);
        inv = 8'd100; ivalid = 1'b1;
        @(negedge clock);
        ivalid = 1'b0;
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_eq("mid_rst_ovalid", int'(ovalid), 0);
        chk_eq("mid_rst_outv", int'(outv), 0);
        chk_eq("mid_rst_iready", int'(iready), 1);
        do_pixel(100, 109);

        // random stream against a queue-based model
        sent = 0; recvd = 0; cyc = 0; acc_prev = 1'b0;
        while (recvd < 1000 && cyc < 60000) begin
            @(negedge clock);
            cyc++;
            if (acc_prev) ivalid = 1'b0;
            acc_prev = 1'b0;
            if (!ivalid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                ivalid = 1'b1;
                inv = 8'($urandom_range(0, 255));
            end
            oready = ($urandom_range(0, 2) != 0);
            #1;
            if (ivalid && iready) begin
                q_d.push_back(ref_out(int'(inv), 3, 2, 64));
                q_s.push_back(ref_out(int'(inv), 1, 2, 64));
                sent++;
                acc_prev = 1'b1;
            end
            if (ovalid && oready) begin
                if (q_d.size() == 0) begin
                    chk_eq("rnd_spurious_out", 1, 0);
                end else begin
                    chk_eq("rnd_outv", int'(outv), q_d.pop_front());
                    chk_eq("rnd_ovalid_s", int'(ovalid_s), 1);
                    chk_eq("rnd_outv_s", int'(outv_s), q_s.pop_front());
                end
                recvd++;
            end
        end
        ivalid = 1'b0; oready = 1'b0;
        chk_eq("rnd_sent", sent, 1000);
        chk_eq("rnd_recvd", recvd, 1000);
        chk_eq("rnd_leftover", q_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/contrast_inverse.md
# contrast_inverse

Streaming inverse of the fixed contrast-stretch transform. It recovers the original 8-bit pixel from a stretched one: outv = min(255, floor((inv + N) * FRAC_DEN / FRAC_NUM)). The block uses a valid/ready handshake and a multi-cycle restoring divider, so no combinational divider is needed. It sits on the image-decompression side of the pipeline, downstream of any stage that has applied the stretch.

## Interface
- FRAC_NUM, 3, slope numerator of the forward transform; legal range 1..255 (0 is rejected at elaboration).
- FRAC_DEN, 2, slope denominator of the forward transform; legal range 1..255.
- N, 64, forward-transform offset; legal range 0..255.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- ivalid  in  1  inv is valid this cycle.
- iready  out  1  block accepts inv this cycle.
- inv  in  8  stretched pixel, unsigned.
- ovalid  out  1  outv is valid and held stable.
- oready  in  1  downstream accepts outv this cycle.
- outv  out  8  recovered pixel, unsigned.

## Operation
- Dividend D = (inv + N) * FRAC_DEN.
  - Width: inv + N is 9 bits; the product is held in 17 bits (max 510*255 = 130050).
  - Divisor is FRAC_NUM, 8 bits.
- Restoring division, one quotient bit per cycle, MSB first, 17 iterations.
  - Quotient is 17 bits; remainder register is 9 bits.
  - Quotient is truncated; no rounding.
- Saturation: if quotient > 255, outv = 255; else outv = quotient[7:0]. Saturation is applied when entering DONE.
- States:
  - IDLE: iready = 1, ovalid = 0. On ivalid && iready, latch D, clear quotient, remainder and iteration counter, go to DIV.
  - DIV: iready = 0, ovalid = 0. Counter 0..16 advances once per cycle. After iteration 16, write saturated outv and go to DONE.
  - DONE: ovalid = 1, outv stable.
    - oready = 0: stay in DONE.
    - oready = 1, ivalid = 0: go to IDLE.
    - oready = 1, ivalid = 1: iready = 1. The result is consumed and the new pixel accepted on the same edge; go directly to DIV.
- iready = (state == IDLE) || (state == DONE && oready). This is a combinational path from oready to iready; no other input-to-output combinational paths exist.
- ivalid is ignored while iready = 0. The upstream holds inv and ivalid until accepted.
- Reset values: state IDLE, iready 1, ovalid 0, outv 0, counter 0, datapath registers 0.
- Reset mid-operation (DIV or DONE): any in-flight pixel is discarded with no output. On the next cycle, state is IDLE and ovalid = 0.
- Reset has priority over any simultaneous handshake in the same cycle.

## Timing
- Accept edge at cycle k, then 17 DIV cycles. ovalid rises after the edge ending cycle k+17, i.e. it is first high in cycle k+18.
- Latency from accept to first ovalid: 18 cycles.
- Back-to-back throughput with oready held high: one pixel per 18 cycles. DONE lasts 1 cycle and overlaps the next accept.
- outv and ovalid come directly from registers. outv changes only on the transition into DONE, or on reset.
- No back-pressure loss: results persist in DONE indefinitely while oready = 0.

## Test plan
- Reset then single pixel, default parameters:
  - inv = 128 -> outv = 128 (384/3); ovalid first high 18 cycles after accept.
  - inv = 0 -> outv = 42 (128/3 truncated).
- Top end, default parameters: inv = 255 -> outv = 212 (638/3 = 212.67, truncated). No saturation occurs.
- Saturation with FRAC_NUM = 1, FRAC_DEN = 2, N = 64: inv = 200 -> outv = 255 (raw 528). Also inv = 63 -> outv = 254.
- Back-pressure: hold oready = 0 for 10 cycles after ovalid rises.
  - outv stays stable and iready stays 0 throughout.
  - Raising oready with ivalid = 1 and inv = 30 consumes the old result and accepts the new pixel on the same edge.
  - Next output is 62 (188/3).
- Reset mid-operation:
  - Assert reset in DIV cycle 8 for inv = 100 -> next cycle ovalid = 0, outv = 0, iready = 1.
  - A subsequent inv = 100 -> outv = 109 (328/3), with no stale output in between.
- Random stream of 1000 pixels with random ivalid/oready gaps: every accepted inv yields exactly one outv, in order, matching the reference formula.
